// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encodings, default width, counter sizing.
package div_pkg;

  localparam int N_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Iteration counter must hold 0..2N.
  function automatic int cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(N_DEF);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Zero latency, no state, no flow control.
module div_step
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   r_i,
  input  logic         dq_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   r_o,
  output logic         q_bit_o
);

  logic [N:0] t;

  assign t = {r_i[N-1:0], dq_msb_i};

  // r_i[N] stands for the bit shifted out of t; when set, t is certainly >= divisor.
  assign q_bit_o = r_i[N] | (t >= {1'b0, divisor_i});
  assign r_o     = q_bit_o ? (t - {1'b0, divisor_i}) : t;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock: 2N cycles to result (divide-by-zero: next cycle).
// Valid/ready on both sides; result held in DONE until out_ready, in_ready only while IDLE.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int             CW   = cnt_w(N);
  localparam logic [CW-1:0]  LAST = CW'(2 * N - 1);

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] dq_q, dq_d;
  logic [2*N-1:0] quo_q, quo_d;
  logic [N:0]     r_q, r_d, r_nxt;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           q_bit;

  div_step #(.N(N)) u_step (
    .r_i       (r_q),
    .dq_msb_i  (dq_q[2*N-1]),
    .divisor_i (dvs_q),
    .r_o       (r_nxt),
    .q_bit_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rem_d   = dividend[N-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            dq_d    = dividend;
            r_d     = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        dq_d  = {dq_q[2*N-2:0], q_bit};
        r_d   = r_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          quo_d   = {dq_q[2*N-2:0], q_bit};
          rem_d   = r_nxt[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      ST_DONE: begin
        // Result registers clear on the handshake so they read zero whenever out_valid is low.
        if (out_ready) begin
          state_d = ST_IDLE;
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dq_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
